z8_data_mem: RTL
================

# z8_data_mem

Data-memory responder for the z8 processor core. Accepts the core's MEM_READ/MEM_WRITE requests over a valid/ready handshake and returns one response per request after a fixed wait. Also owns the hardware stack used by PSHR/PSHD/POP, as a downward-growing region at the top of data memory.

## Interface
- MEM_SIZE, default DATA_MEM_SIZE (256): number of 8-bit words. Addresses at or above MEM_SIZE are invalid.
- STACK_DEPTH, default 16: stack capacity in words. Occupies addresses MEM_SIZE-STACK_DEPTH .. MEM_SIZE-1.
- WAIT_CYCLES, default 1 (minimum 1): cycles spent in ACCESS.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_op  in  2  MEM_OPS_T: MEM_NOP, MEM_READ or MEM_WRITE.
- req_stack  in  1  stack access. With MEM_WRITE this is a push; with MEM_READ it is a pop; req_addr is ignored.
- req_addr  in  8  word address for non-stack accesses.
- req_wdata  in  8  write or push data.
- rsp_valid  out  1  one-cycle response strobe. Has no backpressure.
- rsp_rdata  out  8  read or pop data; held until the next response.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- sp  out  8  current stack pointer, i.e. the next free slot.

## Operation
- FSM with three states: DM_IDLE -> DM_ACCESS -> DM_RESPOND -> DM_IDLE.
  - DM_IDLE: req_ready=1. On req_valid the request is latched at the edge and the FSM moves to DM_ACCESS.
  - DM_ACCESS: a wait counter runs for WAIT_CYCLES cycles. On the last of these edges the memory operation executes and the FSM moves to DM_RESPOND.
  - DM_RESPOND: rsp_valid=1 for exactly one cycle, then DM_IDLE.
- Stack state: a count register, 0..STACK_DEPTH, with sp = MEM_SIZE-1-count.
  - Push: mem[sp] <= wdata, then count+1.
  - Pop: count-1, then rdata <= mem[new sp], which is the last pushed word.
- Response data by operation:
  - MEM_READ: rsp_rdata = mem[addr].
  - MEM_WRITE: echoes wdata.
  - MEM_NOP: accepted, memory untouched, rsp_rdata=0, rsp_err=0.
- Errors (rsp_err=1). In every error case memory and count are unchanged.
  - Push with count==STACK_DEPTH (full).
  - Pop with count==0 (empty); rsp_rdata=0.
  - Non-stack access with addr>=MEM_SIZE; write dropped, rsp_rdata=0.
- Non-stack accesses into the stack region are permitted and unprotected.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, count=0, sp=MEM_SIZE-1, FSM=DM_IDLE. Memory contents are not reset.

## Timing
- A request accepted at edge k performs its memory operation at edge k+WAIT_CYCLES.
- rsp_valid is high from edge k+WAIT_CYCLES to edge k+WAIT_CYCLES+1.
- req_ready is low from edge k until edge k+WAIT_CYCLES+1.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- req_* inputs are sampled only at the accepting edge; later changes have no effect.
- rst asserted mid-request aborts it:
  - FSM goes to DM_IDLE and rsp_valid drops immediately; no response is ever issued.
  - If rst arrives before the operation edge, no write occurs.
- sp updates at the operation edge, in the same cycle that rsp_valid rises.

## Configuration
- Macro Z8_DMEM_STACK_CHECK_EN.
- Defined: full, empty and out-of-range checks as above.
- Undefined: no checks and rsp_err is tied to 0.
  - count wraps modulo STACK_DEPTH+1: a push when full sets count to 0, a pop when empty sets it to STACK_DEPTH.
  - An out-of-range address indexes memory modulo MEM_SIZE.

## Structure
- Shared package instruction_set gains:
  - typedef DMEM_STATE_T {DM_IDLE, DM_ACCESS, DM_RESPOND};
  - parameter STACK_DEPTH = 16.
- The block reuses MEM_OPS_T and DATA_MEM_SIZE from the same package.
- One sub-module, z8_dmem_array: a single-port synchronous RAM, MEM_SIZE x 8, with write enable and registered read. It is instantiated once.

## Test plan
- Write/read: WRITE addr 0x10 data 0xA5, then READ 0x10 -> rsp_rdata=0xA5, rsp_err=0; with WAIT_CYCLES=1, rsp_valid is high exactly 1 edge after acceptance.
- LIFO: push 0x11, 0x22, 0x33, then pop three times -> 0x33, 0x22, 0x11. sp goes 0xFF->0xFC->0xFF.
- Overflow: 16 pushes, then a 17th push of 0x77 -> rsp_err=1, sp=0xEF; the next pop returns the 16th pushed value.
- Underflow: pop after reset -> rsp_err=1, rsp_rdata=0, sp=0xFF. With the macro undefined -> rsp_err=0 and sp=0xEF.
- Reset mid-op: WAIT_CYCLES=3, WRITE 0x20 data 0x5A, rst asserted after 1 cycle -> no rsp_valid, req_ready=1; a later READ 0x20 does not return 0x5A (preload 0x00).
- NOP and hold: MEM_NOP -> response with rdata 0; req_valid held through the busy period -> exactly one request accepted per WAIT_CYCLES+2 cycles.

Source files
------------

// File: rtl/instruction_set.sv
// Shared z8 core definitions: memory operation codes, data-memory FSM states,
// memory/stack sizes and the stack slot address helper.
package instruction_set;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } MEM_OPS_T;

  typedef enum logic [1:0] {
    DM_IDLE    = 2'd0,
    DM_ACCESS  = 2'd1,
    DM_RESPOND = 2'd2
  } DMEM_STATE_T;

  parameter int DATA_MEM_SIZE = 256;
  parameter int STACK_DEPTH   = 16;

  // The stack grows downward from the top word; 'count' words are in use.
  function automatic int stack_slot(input int mem_size, input int count);
    return mem_size - 1 - count;
  endfunction

endpackage

// File: rtl/z8_dmem_array.sv
// Single-port synchronous RAM, MEM_SIZE x 8, with write enable and registered read.
module z8_dmem_array #(
  parameter int MEM_SIZE = 256,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MEM_SIZE];

  // Read data only moves on an enabled read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/z8_data_mem.sv
// z8 data-memory responder with a downward-growing hardware stack at the top of memory.
// Define Z8_DMEM_STACK_CHECK_EN to report full/empty/out-of-range errors on rsp_err.
//
// state      | meaning
// DM_IDLE    | req_ready high, waiting for a request
// DM_ACCESS  | wait counter running; operation executes on its terminal count
// DM_RESPOND | rsp_valid strobe for one cycle
module z8_data_mem #(
  parameter int MEM_SIZE    = instruction_set::DATA_MEM_SIZE,
  parameter int STACK_DEPTH = instruction_set::STACK_DEPTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  instruction_set::MEM_OPS_T req_op,
  input  logic                      req_stack,
  input  logic [7:0]                req_addr,
  input  logic [7:0]                req_wdata,
  output logic                      rsp_valid,
  output logic [7:0]                rsp_rdata,
  output logic                      rsp_err,
  output logic [7:0]                sp
);
  import instruction_set::*;

  localparam int AW  = $clog2(MEM_SIZE);
  localparam int CW  = $clog2(STACK_DEPTH + 1);
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0]  DEPTH_C   = CW'(STACK_DEPTH);

  DMEM_STATE_T    state_q, state_d;
  MEM_OPS_T       op_q;
  logic           stack_q;
  logic [7:0]     addr_q, wdata_q;
  logic [WCW-1:0] wait_q;
  logic [CW-1:0]  count_q, count_inc, count_dec;

  logic           accept, do_op, op_err;
  logic           is_read, is_write, is_push, is_pop, full, empty;
  logic [AW-1:0]  lin_addr, push_addr, pop_addr;
  logic           ram_en, ram_we;
  logic [AW-1:0]  ram_addr;
  logic [7:0]     ram_rdata;
  logic           rsp_from_ram_q;
  logic [7:0]     rsp_data_q;

  assign req_ready = (state_q == DM_IDLE);
  assign rsp_valid = (state_q == DM_RESPOND);
  assign accept    = req_ready && req_valid;
  assign do_op     = (state_q == DM_ACCESS) && (wait_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DM_IDLE:    if (req_valid) state_d = DM_ACCESS;
      DM_ACCESS:  if (wait_q == '0) state_d = DM_RESPOND;
      DM_RESPOND: state_d = DM_IDLE;
      default:    state_d = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DM_IDLE;
      op_q    <= MEM_NOP;
      stack_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op;
        stack_q <= req_stack;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wait_q  <= WAIT_LOAD;
      end else if (state_q == DM_ACCESS && wait_q != '0) begin
        wait_q <= wait_q - 1'b1;
      end
    end
  end

  assign is_read  = (op_q == MEM_READ);
  assign is_write = (op_q == MEM_WRITE);
  assign is_push  = is_write && stack_q;
  assign is_pop   = is_read && stack_q;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);

  // Wrap-around only takes effect when the error checks are compiled out.
  assign count_inc = full  ? '0      : count_q + 1'b1;
  assign count_dec = empty ? DEPTH_C : count_q - 1'b1;

  assign lin_addr  = AW'(int'({24'd0, addr_q}) % MEM_SIZE);
  assign push_addr = AW'(stack_slot(MEM_SIZE, int'(count_q)));
  assign pop_addr  = AW'(stack_slot(MEM_SIZE, int'(count_dec)));

`ifdef Z8_DMEM_STACK_CHECK_EN
  logic addr_oor, rsp_err_q;
  assign addr_oor = int'({24'd0, addr_q}) >= MEM_SIZE;
  assign op_err   = (is_push && full) || (is_pop && empty) ||
                    (!stack_q && (is_read || is_write) && addr_oor);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rsp_err_q <= 1'b0;
    else if (do_op) rsp_err_q <= op_err;
  end
  assign rsp_err = rsp_err_q;
`else
  assign op_err  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign ram_en   = do_op && !op_err && (is_read || is_write);
  assign ram_we   = is_write;
  assign ram_addr = stack_q ? (is_write ? push_addr : pop_addr) : lin_addr;

  z8_dmem_array #(
    .MEM_SIZE (MEM_SIZE),
    .AW       (AW)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q        <= '0;
      rsp_from_ram_q <= 1'b0;
      rsp_data_q     <= 8'h00;
    end else if (do_op) begin
      if (!op_err) begin
        if (is_push)     count_q <= count_inc;
        else if (is_pop) count_q <= count_dec;
      end
      rsp_from_ram_q <= ram_en && !ram_we;
      // Writes echo their data unless dropped for a bad address.
      rsp_data_q     <= (is_write && !(op_err && !stack_q)) ? wdata_q : 8'h00;
    end
  end

  // The RAM read register only changes on a read, which also sets rsp_from_ram_q.
  assign rsp_rdata = rsp_from_ram_q ? ram_rdata : rsp_data_q;
  assign sp        = 8'(stack_slot(MEM_SIZE, int'(count_q)));

endmodule
